pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/pipeline_ctrl_sat_counter.sv | 30 +++
 rtl/pipeline_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_types
//   Shared types for the pipeline hazard controller.
//   - REG_IDX_W    : width of an architectural register index
//   - pipe_state_t : encoded miss state. The encoding is {d_pend, i_pend}, so
//                    the next state is simply the two pending flags
//                    concatenated.
// -----------------------------------------------------------------------------
package rv32i_types;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        IMISS  = 2'd1,
        DMISS  = 2'd2,
        IDMISS = 2'd3
    } pipe_state_t;

endpackage : rv32i_types

// File: rtl/pipeline_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter used for the performance counters. It holds at the
//   all-ones value instead of wrapping around.
//   Ports:
//     clk   in  : clock, counts on the rising edge
//     rst   in  : asynchronous active-high clear
//     inc   in  : count this cycle
//     count out : current value (W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Hazard and stall controller for a 5-stage in-order pipeline. It combines
//   outstanding memory misses, EX-stage redirects and load-use hazards into
//   per-register stall/flush controls, and keeps stall-cause counters.
//   The priority is memory freeze > redirect > load-use.
//   Ports:
//     clk, rst                      : clock, async active-high reset
//     imem_read, imem_resp          : fetch request / fetch data returned
//     dmem_read, dmem_write         : MEM-stage load / store in progress
//     dmem_resp                     : data access completes this cycle
//     id_rs1, id_rs2                : ID-stage source register indices
//     id_use_rs1, id_use_rs2        : ID instruction reads that source
//     ex_rd, ex_is_load             : EX destination index / EX is a load
//     ex_br_taken                   : EX control transfer redirects the PC
//     *_stall                       : hold the named pipeline register
//     if_id_flush, id_ex_flush      : load a bubble into the named register
//     perf_imiss/dmiss/lu/redir     : saturating cause counters (CNT_W bits)
//     miss_state                    : registered {d_pend, i_pend}
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_read,
    input  logic                 imem_resp,
    input  logic                 dmem_read,
    input  logic                 dmem_write,
    input  logic                 dmem_resp,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_is_load,
    input  logic                 ex_br_taken,
    output logic                 pc_stall,
    output logic                 if_id_stall,
    output logic                 id_ex_stall,
    output logic                 ex_mem_stall,
    output logic                 mem_wb_stall,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic [CNT_W-1:0]     perf_imiss,
    output logic [CNT_W-1:0]     perf_dmiss,
    output logic [CNT_W-1:0]     perf_lu,
    output logic [CNT_W-1:0]     perf_redir,
    output logic [1:0]           miss_state
);

    logic        w_i_pend;
    logic        w_d_pend;
    logic        w_freeze;
    logic        w_load_use;
    logic        w_redir;
    logic        w_bubble;
    pipe_state_t r_state;

    // A response in the same cycle as its request is not a miss.
    assign w_i_pend = imem_read & ~imem_resp;
    assign w_d_pend = (dmem_read | dmem_write) & ~dmem_resp;
    assign w_freeze = w_i_pend | w_d_pend;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign w_load_use = ex_is_load && (ex_rd != '0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));

    // Only unfrozen events take effect; a redirect squashes the dependent
    // instruction anyway, so load-use under a redirect inserts no bubble.
    assign w_redir  = ~w_freeze & ex_br_taken;
    assign w_bubble = ~w_freeze & ~ex_br_taken & w_load_use;

    // NOTE: every output of this always_comb gets a default first, so no
    // path through the if/else chain can infer a latch.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        if (w_freeze) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
        end else if (ex_br_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (w_load_use) begin
            // Hold PC and IF/ID, push a bubble into EX.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
        end
    end

    // The state encoding equals {d_pend, i_pend}, so it is a direct cast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= pipe_state_t'({w_d_pend, w_i_pend});
        end
    end

    assign miss_state = r_state;

    sat_counter #(.W(CNT_W)) u_cnt_imiss (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_i_pend),
        .count (perf_imiss)
    );

    sat_counter #(.W(CNT_W)) u_cnt_dmiss (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_d_pend),
        .count (perf_dmiss)
    );

    sat_counter #(.W(CNT_W)) u_cnt_lu (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_bubble),
        .count (perf_lu)
    );

    sat_counter #(.W(CNT_W)) u_cnt_redir (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_redir),
        .count (perf_redir)
    );

endmodule : pipeline_ctrl

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed vectors with hand-computed expectations. Each vector is driven
//   just after a rising edge and its expectation pushed into a queue; a
//   monitor pops and compares on the falling edge. Stall vector order is
//   {pc, if_id, id_ex, ex_mem, mem_wb}; flush order is {if_id, id_ex}.
//   Counters and state in an expectation are the values visible during that
//   vector, i.e. after all earlier vectors have been clocked in.
//   A second instance with CNT_W=4 shares the inputs to check saturation.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    typedef struct {
        logic [4:0] stall;
        logic [1:0] flush;
        logic [1:0] st;
        int         im;
        int         dm;
        int         lu;
        int         rd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken;

    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
    logic        if_id_flush, id_ex_flush;
    logic [15:0] perf_imiss, perf_dmiss, perf_lu, perf_redir;
    logic [1:0]  miss_state;

    logic        s_pc_stall, s_if_id_stall, s_id_ex_stall, s_ex_mem_stall, s_mem_wb_stall;
    logic        s_if_id_flush, s_id_ex_flush;
    logic [3:0]  s_perf_imiss, s_perf_dmiss, s_perf_lu, s_perf_redir;
    logic [1:0]  s_miss_state;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .perf_imiss(perf_imiss), .perf_dmiss(perf_dmiss),
        .perf_lu(perf_lu), .perf_redir(perf_redir),
        .miss_state(miss_state)
    );

    pipeline_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
        .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .id_ex_stall(s_id_ex_stall),
        .ex_mem_stall(s_ex_mem_stall), .mem_wb_stall(s_mem_wb_stall),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .perf_imiss(s_perf_imiss), .perf_dmiss(s_perf_dmiss),
        .perf_lu(s_perf_lu), .perf_redir(s_perf_redir),
        .miss_state(s_miss_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        imem_read = 0; imem_resp = 0; dmem_read = 0; dmem_write = 0; dmem_resp = 0;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_is_load = 0; ex_br_taken = 0;
    endtask

    // Start a new vector: wait for the edge, then reset inputs to idle.
    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_out(input logic [4:0] stall, input logic [1:0] flush,
                              input logic [1:0] st, input int im, input int dm,
                              input int lu, input int rd);
        exp_t e;
        e.stall = stall; e.flush = flush; e.st = st;
        e.im = im; e.dm = dm; e.lu = lu; e.rd = rd;
        q.push_back(e);
    endtask

    // Monitor: compares the DUT against the oldest expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("stalls", {27'd0, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall}, {27'd0, e.stall});
            check("flushes", {30'd0, if_id_flush, id_ex_flush}, {30'd0, e.flush});
            check("miss_state", {30'd0, miss_state}, {30'd0, e.st});
            check("perf_imiss", {16'd0, perf_imiss}, e.im);
            check("perf_dmiss", {16'd0, perf_dmiss}, e.dm);
            check("perf_lu", {16'd0, perf_lu}, e.lu);
            check("perf_redir", {16'd0, perf_redir}, e.rd);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b1;
        #2;
        check("reset miss_state", {30'd0, miss_state}, 32'd0);
        check("reset perf_imiss", {16'd0, perf_imiss}, 32'd0);
        check("reset stalls", {31'd0, pc_stall}, 32'd0);
        #5 rst = 1'b0;

        next(); expect_out(5'b00000, 2'b00, 2'd0, 0, 0, 0, 0);
        // Instruction miss for 3 cycles, response on the 4th.
        next(); imem_read = 1; expect_out(5'b11111, 2'b00, 2'd0, 0, 0, 0, 0);
        next(); imem_read = 1; expect_out(5'b11111, 2'b00, 2'd1, 1, 0, 0, 0);
        next(); imem_read = 1; expect_out(5'b11111, 2'b00, 2'd1, 2, 0, 0, 0);
        next(); imem_read = 1; imem_resp = 1; expect_out(5'b00000, 2'b00, 2'd1, 3, 0, 0, 0);
        next(); expect_out(5'b00000, 2'b00, 2'd0, 3, 0, 0, 0);
        // Load-use via rs2.
        next(); ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        expect_out(5'b11000, 2'b01, 2'd0, 3, 0, 0, 0);
        next(); expect_out(5'b00000, 2'b00, 2'd0, 3, 0, 1, 0);
        // Load to x0 with matching rs1: no hazard.
        next(); ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        expect_out(5'b00000, 2'b00, 2'd0, 3, 0, 1, 0);
        // Matching rs1 that is not used.
        next(); ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_rs2 = 3; id_use_rs2 = 1;
        expect_out(5'b00000, 2'b00, 2'd0, 3, 0, 1, 0);
        // Matching rs1 but EX is not a load.
        next(); ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
        expect_out(5'b00000, 2'b00, 2'd0, 3, 0, 1, 0);
        // Redirect together with load-use: flushes only.
        next(); ex_br_taken = 1; ex_is_load = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1;
        expect_out(5'b00000, 2'b11, 2'd0, 3, 0, 1, 0);
        next(); expect_out(5'b00000, 2'b00, 2'd0, 3, 0, 1, 1);
        // Data miss under a redirect, then response.
        next(); dmem_read = 1; ex_br_taken = 1; expect_out(5'b11111, 2'b00, 2'd0, 3, 0, 1, 1);
        next(); dmem_read = 1; ex_br_taken = 1; expect_out(5'b11111, 2'b00, 2'd2, 3, 1, 1, 1);
        next(); dmem_read = 1; dmem_resp = 1; ex_br_taken = 1;
        expect_out(5'b00000, 2'b11, 2'd2, 3, 2, 1, 1);
        next(); expect_out(5'b00000, 2'b00, 2'd0, 3, 2, 1, 2);
        // Both misses at once.
        next(); imem_read = 1; dmem_write = 1; expect_out(5'b11111, 2'b00, 2'd0, 3, 2, 1, 2);
        next(); expect_out(5'b00000, 2'b00, 2'd3, 4, 3, 1, 2);
        // Store miss hides a load-use.
        next(); dmem_write = 1; ex_is_load = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
        expect_out(5'b11111, 2'b00, 2'd0, 4, 3, 1, 2);
        next(); expect_out(5'b00000, 2'b00, 2'd2, 4, 4, 1, 2);
        // Same-cycle responses are not misses.
        next(); imem_read = 1; imem_resp = 1; dmem_read = 1; dmem_resp = 1;
        expect_out(5'b00000, 2'b00, 2'd0, 4, 4, 1, 2);
        next(); expect_out(5'b00000, 2'b00, 2'd0, 4, 4, 1, 2);
        // 20 instruction-miss cycles.
        for (int i = 0; i < 20; i++) begin
            next(); imem_read = 1;
            expect_out(5'b11111, 2'b00, (i == 0) ? 2'd0 : 2'd1, 4 + i, 4, 1, 2);
        end

        @(posedge clk);
        #1;
        check("q drained", q.size(), 32'd0);
        check("imiss wide", {16'd0, perf_imiss}, 32'd24);
        check("imiss sat", {28'd0, s_perf_imiss}, 32'd15);
        check("dmiss sat", {28'd0, s_perf_dmiss}, 32'd4);
        // Reset mid-miss, between clock edges.
        #1 rst = 1'b1;
        #1;
        check("rst miss_state", {30'd0, miss_state}, 32'd0);
        check("rst imiss", {16'd0, perf_imiss}, 32'd0);
        check("rst dmiss", {16'd0, perf_dmiss}, 32'd0);
        check("rst redir", {16'd0, perf_redir}, 32'd0);
        check("rst sat imiss", {28'd0, s_perf_imiss}, 32'd0);
        check("rst stalls comb", {31'd0, pc_stall}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("resume imiss", {16'd0, perf_imiss}, 32'd1);
        check("resume state", {30'd0, miss_state}, 32'd1);
        idle();
        #1;
        check("idle stalls", {31'd0, pc_stall}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipeline_ctrl
